// File: rtl/multi_data_sink.sv
// ---------------------------------------------------------------------------
// multi_data_sink
//
// Per-stream configurable data sink. A shared config handshake pushes one
// 2-bit mode per stream into small per-stream queues. The head mode of each
// queue decides how the stream's current transaction is handled:
//   00 DISCARD        : beats are dropped, only a keep-less last beat is sent
//   01 FORWARD        : beats pass through unchanged
//   10 DISCARD_REPORT : as DISCARD, plus the dropped element count is reported
//   11                : treated as DISCARD
// The queue head pops on the accepted last beat of the transaction.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   cfg_valid/cfg_ready/cfg_mode    config push (mode of stream s at [2s+1:2s])
//   in_valid/in_ready/in_last       per-stream input handshake
//   in_data/in_keep                 per-stream input payload
//   out_valid/out_ready/out_last    per-stream output handshake
//   out_data/out_keep               per-stream output payload
//   stat_valid/stat_ready           per-stream drop-report handshake
//   stat_count                      32-bit dropped-element count per stream
// ---------------------------------------------------------------------------
module multi_data_sink #(
  parameter int NUM_STREAMS  = 4,
  parameter int NUM_ELEMENTS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int CFG_DEPTH    = 4,
  parameter int OUT_REG      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  input  logic [2*NUM_STREAMS-1:0]                  cfg_mode,
  input  logic [NUM_STREAMS-1:0]                    in_valid,
  output logic [NUM_STREAMS-1:0]                    in_ready,
  input  logic [NUM_STREAMS-1:0]                    in_last,
  input  logic [NUM_STREAMS*NUM_ELEMENTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_STREAMS*NUM_ELEMENTS-1:0]       in_keep,
  output logic [NUM_STREAMS-1:0]                    out_valid,
  input  logic [NUM_STREAMS-1:0]                    out_ready,
  output logic [NUM_STREAMS-1:0]                    out_last,
  output logic [NUM_STREAMS*NUM_ELEMENTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_STREAMS*NUM_ELEMENTS-1:0]       out_keep,
  output logic [NUM_STREAMS-1:0]                    stat_valid,
  input  logic [NUM_STREAMS-1:0]                    stat_ready,
  output logic [32*NUM_STREAMS-1:0]                 stat_count
);

  localparam int BEAT_W = NUM_ELEMENTS * DATA_WIDTH;
  localparam int PTR_W  = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  // Config is accepted only when every queue has room, so all queues push
  // together and never overflow.
  logic [NUM_STREAMS-1:0] q_full;
  logic                   cfg_push;

  assign cfg_ready = ~|q_full;
  assign cfg_push  = cfg_valid && cfg_ready;

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
    // ---------------- config queue ----------------
    logic [1:0]       q_mem [CFG_DEPTH];
    logic [PTR_W-1:0] q_wr_ptr_reg;
    logic [PTR_W-1:0] q_rd_ptr_reg;
    logic [CNT_W-1:0] q_count_reg;
    logic             q_empty;
    logic             q_pop;
    logic [1:0]       head_mode;
    logic             is_fwd;
    logic             is_rep;

    assign q_empty     = (q_count_reg == '0);
    assign q_full[gi]  = (q_count_reg == CNT_W'(CFG_DEPTH));
    assign head_mode   = q_mem[q_rd_ptr_reg];
    assign is_fwd      = (head_mode == 2'b01);
    assign is_rep      = (head_mode == 2'b10);

    always_ff @(posedge clk) begin
      if (cfg_push) begin
        q_mem[q_wr_ptr_reg] <= cfg_mode[2*gi +: 2];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_wr_ptr_reg <= '0;
        q_rd_ptr_reg <= '0;
        q_count_reg  <= '0;
      end else begin
        if (cfg_push) q_wr_ptr_reg <= q_wr_ptr_reg + 1'b1;
        if (q_pop)    q_rd_ptr_reg <= q_rd_ptr_reg + 1'b1;
        q_count_reg <= q_count_reg + CNT_W'(cfg_push) - CNT_W'(q_pop);
      end
    end

    // ---------------- input side ----------------
    logic              in_valid_s;
    logic              in_last_s;
    logic [BEAT_W-1:0] in_data_s;
    logic [NUM_ELEMENTS-1:0] in_keep_s;

    assign in_valid_s = in_valid[gi];
    assign in_last_s  = in_last[gi];
    assign in_data_s  = in_data[gi*BEAT_W +: BEAT_W];
    assign in_keep_s  = in_keep[gi*NUM_ELEMENTS +: NUM_ELEMENTS];

    logic        stat_valid_reg;
    logic [31:0] stat_count_reg;
    logic [31:0] drop_cnt_reg;
    logic        stat_free;

    // The report slot is free if empty or being drained this very cycle.
    assign stat_free = !stat_valid_reg || stat_ready[gi];

    logic                    stage_valid;
    logic                    stage_ready;
    logic                    stage_push;
    logic                    in_ready_s;
    logic                    accept;
    logic [NUM_ELEMENTS-1:0] stage_keep;
    logic                    stage_last;

    always_comb begin
      stage_valid = 1'b0;
      in_ready_s  = 1'b0;
      if (!q_empty) begin
        if (is_fwd) begin
          stage_valid = in_valid_s;
          in_ready_s  = stage_ready;
        end else if (!in_last_s) begin
          // Dropped beats are swallowed without touching the output.
          in_ready_s = 1'b1;
        end else if (is_rep) begin
          stage_valid = in_valid_s && stat_free;
          in_ready_s  = stage_ready && stat_free;
        end else begin
          stage_valid = in_valid_s;
          in_ready_s  = stage_ready;
        end
      end
    end

    assign accept       = in_valid_s && in_ready_s;
    assign q_pop        = accept && in_last_s;
    assign stage_push   = stage_valid && stage_ready;
    assign stage_keep   = is_fwd ? in_keep_s : '0;
    assign stage_last   = is_fwd ? in_last_s : 1'b1;
    assign in_ready[gi] = in_ready_s;

    // ---------------- drop counter and report ----------------
    logic [31:0] keep_pop;
    logic [32:0] sum_wide;
    logic [31:0] sum_sat;

    always_comb begin
      keep_pop = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        keep_pop = keep_pop + 32'(in_keep_s[i]);
      end
    end

    assign sum_wide = {1'b0, drop_cnt_reg} + {1'b0, keep_pop};
    assign sum_sat  = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        drop_cnt_reg   <= '0;
        stat_valid_reg <= 1'b0;
        stat_count_reg <= '0;
      end else begin
        if (accept && !is_fwd) begin
          drop_cnt_reg <= in_last_s ? 32'd0 : sum_sat;
        end
        if (accept && !is_fwd && in_last_s && is_rep) begin
          stat_valid_reg <= 1'b1;
          stat_count_reg <= sum_sat;
        end else if (stat_ready[gi]) begin
          stat_valid_reg <= 1'b0;
        end
      end
    end

    assign stat_valid[gi]            = stat_valid_reg;
    assign stat_count[gi*32 +: 32]   = stat_count_reg;

    // ---------------- output stage ----------------
    if (OUT_REG != 0) begin : g_skid
      // Two-entry buffer: ready depends only on occupancy, so there is no
      // combinational path from out_ready back to in_ready.
      logic [BEAT_W-1:0]       sb_data_reg [2];
      logic [NUM_ELEMENTS-1:0] sb_keep_reg [2];
      logic                    sb_last_reg [2];
      logic                    sb_wr_ptr_reg;
      logic                    sb_rd_ptr_reg;
      logic [1:0]              sb_count_reg;
      logic                    sb_pop;

      assign stage_ready = (sb_count_reg != 2'd2);
      assign sb_pop      = (sb_count_reg != 2'd0) && out_ready[gi];

      always_ff @(posedge clk) begin
        if (stage_push) begin
          sb_data_reg[sb_wr_ptr_reg] <= in_data_s;
          sb_keep_reg[sb_wr_ptr_reg] <= stage_keep;
          sb_last_reg[sb_wr_ptr_reg] <= stage_last;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sb_wr_ptr_reg <= 1'b0;
          sb_rd_ptr_reg <= 1'b0;
          sb_count_reg  <= 2'd0;
        end else begin
          if (stage_push) sb_wr_ptr_reg <= ~sb_wr_ptr_reg;
          if (sb_pop)     sb_rd_ptr_reg <= ~sb_rd_ptr_reg;
          sb_count_reg <= sb_count_reg + 2'(stage_push) - 2'(sb_pop);
        end
      end

      assign out_valid[gi]                          = (sb_count_reg != 2'd0);
      assign out_data[gi*BEAT_W +: BEAT_W]          = sb_data_reg[sb_rd_ptr_reg];
      assign out_keep[gi*NUM_ELEMENTS +: NUM_ELEMENTS] = sb_keep_reg[sb_rd_ptr_reg];
      assign out_last[gi]                           = sb_last_reg[sb_rd_ptr_reg];
    end else begin : g_pass
      assign stage_ready                            = out_ready[gi];
      assign out_valid[gi]                          = stage_valid;
      assign out_data[gi*BEAT_W +: BEAT_W]          = in_data_s;
      assign out_keep[gi*NUM_ELEMENTS +: NUM_ELEMENTS] = stage_keep;
      assign out_last[gi]                           = stage_last;
    end
  end

endmodule

// File: doc/multi_data_sink.md
MULTI_DATA_SINK -- requirements
Module: multi_data_sink

Interface
- REQ-001: Parameter NUM_STREAMS, default 4, number of independent streams (1..16).
- REQ-002: Parameter NUM_ELEMENTS, default 4, elements per beat.
- REQ-003: Parameter DATA_WIDTH, default 32, bits per element.
- REQ-004: Parameter CFG_DEPTH, default 4, per-stream config queue depth (power of 2, >=2).
- REQ-005: Parameter OUT_REG, default 1; 1 = skid-buffered output per stream, 0 = combinational pass.
- REQ-006: clk  in  1  clock, all logic rising-edge.
- REQ-007: rst_n  in  1  reset, synchronous, active-low.
- REQ-008: cfg_valid / cfg_ready  in / out  1 / 1  config handshake.
- REQ-009: cfg_mode  in  2*NUM_STREAMS  per-stream mode, stream s at bits [2s+1:2s].
- REQ-010: in_valid, in_ready, in_last  in, out, in  NUM_STREAMS each  per-stream input handshake and end of transaction.
- REQ-011: in_data  in  NUM_STREAMS*NUM_ELEMENTS*DATA_WIDTH; in_keep  in  NUM_STREAMS*NUM_ELEMENTS.
- REQ-012: out_valid, out_ready, out_last, out_data, out_keep  out, in, out, out, out  same widths as input.
- REQ-013: stat_valid / stat_ready  out / in  NUM_STREAMS each  per-stream drop-report handshake.
- REQ-014: stat_count  out  32*NUM_STREAMS  elements discarded in reported transaction.

Function
- REQ-015: Modes: 00 DISCARD, 01 FORWARD, 10 DISCARD_REPORT; 11 SHALL behave as DISCARD.
- REQ-016: cfg_ready = 1 iff no stream queue is full; on cfg_valid&&cfg_ready every stream queue pushes its mode field.
- REQ-017: Queue push and pop in the same cycle both take effect; a full queue that pops still deasserts cfg_ready that cycle.
- REQ-018: Config accepted into an empty queue is visible to the stream the following cycle (1-cycle latency to in_ready).
- REQ-019: Empty queue: in_ready[s] = 0, out_valid[s] not asserted by new data.
- REQ-020: Queue head pops on the accepted last beat (in_valid&&in_ready&&in_last) of stream s.
- REQ-021: FORWARD: data, keep, last, valid pass through; in_ready follows the output-stage ready.
- REQ-022: DISCARD/DISCARD_REPORT, non-last beat: in_ready = 1, nothing forwarded.
- REQ-023: DISCARD/DISCARD_REPORT, last beat: forwarded with out_keep all-zero, out_last = 1, data unchanged; in_ready follows the output-stage ready.
- REQ-024: DISCARD_REPORT last beat additionally requires stat slot free (stat_valid[s]=0 or stat_ready[s]=1 same cycle); else in_ready = 0.
- REQ-025: Per-stream 32-bit counter adds popcount(in_keep) on every accepted beat in a discard mode, last beat included; saturates at 0xFFFFFFFF.
- REQ-026: On accepted DISCARD_REPORT last beat: stat_count[s] <= final count, stat_valid[s] <= 1 next cycle; counter clears.
- REQ-027: In DISCARD mode the counter also clears on the last beat; no report.
- REQ-028: stat_valid[s] holds with stable stat_count until stat_ready[s].
- REQ-029: OUT_REG=1: 2-entry skid buffer per stream, 1-cycle latency, full throughput, out_valid never depends combinationally on out_ready, in_ready registered.
- REQ-030: OUT_REG=0: zero latency, output stage ready = out_ready.
- REQ-031: Streams fully independent except the shared config push; a stall on one stream never blocks another's data path.
- REQ-032: Input held without data/keep/last change while in_valid&&!in_ready is assumed; output obeys the same rule.

Reset
- REQ-033: During rst_n=0 and the cycle after: queues empty, counters 0, out_valid = 0, stat_valid = 0, in_ready = 0.
- REQ-034: After reset cfg_ready = 1; stat_count reset value 0.
- REQ-035: Reset mid-transaction discards queued configs, partial counts and buffered beats; no out/stat beat issued for them.

Verification
- REQ-036: Cfg {s0=FORWARD,s1=DISCARD}, 3 beats each, keep=1111 -> s0 emits 3 beats unchanged; s1 emits only last with keep=0000, out_last=1.
- REQ-037: s2 DISCARD_REPORT, 4 beats keep 1111,0011,1111,0001 -> stat_valid[2]=1 with stat_count=11 one cycle after last accept.
- REQ-038: Push CFG_DEPTH configs without traffic -> cfg_ready=0; one last beat on every stream -> cfg_ready=1 next cycle.
- REQ-039: s3 DISCARD_REPORT, stat_ready[3]=0 holding previous report -> second transaction's last beat stalls (in_ready=0) until stat_ready=1; s0 traffic unaffected.
- REQ-040: OUT_REG=1, FORWARD, random out_ready 50% -> no beat lost/duplicated, 1 beat/cycle at out_ready=1.
- REQ-041: Assert rst_n=0 mid-transaction -> all valid outputs 0 following cycle; new config and stream afterwards behave as after first reset.
